// File: rtl/readback_scheduler_pkg.sv
// Shared types and constants for the readback admission scheduler.
// Mode encodings are common with readback_engine.
package readback_scheduler_pkg;

    typedef enum logic [2:0] {
        RbsIdle   = 3'd0,
        RbsCool   = 3'd1,
        RbsDrain  = 3'd2,
        RbsFlush  = 3'd3,
        RbsSwitch = 3'd4
    } rbs_state_e;

    typedef enum logic {
        PendFlush = 1'b0,
        PendMode  = 1'b1
    } rbs_pend_e;

    localparam logic ReadMode = 1'b0;
    localparam logic DiffMode = 1'b1;

    // Cycles spent in COOL after an admit; covers the engine's buffer_space update latency.
    localparam int unsigned RbsCoolCyc = 2;
    localparam int unsigned CoolCntW   = $clog2(RbsCoolCyc + 1);

endpackage

// File: rtl/rd_outstanding_ctr.sv
// Saturating up/down counter of admitted-but-unreturned reads.
// A decrement that would go below zero holds at zero and sets a sticky underflow flag.
module rd_outstanding_ctr #(
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             underflow
);

    localparam logic [CNT_W:0] CntMax = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] count_q, count_d;
    logic             underflow_q, underflow_d;
    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   net;
    logic             dec_ok;

    always_comb begin
        sum         = {1'b0, count_q} + {1'b0, inc};
        dec_ok      = dec && (sum != '0);
        net         = sum - {{CNT_W{1'b0}}, dec_ok};
        underflow_d = underflow_q | (dec && (sum == '0));
        count_d     = (net > CntMax) ? {CNT_W{1'b1}} : net[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign underflow = underflow_q;

endmodule

// File: rtl/readback_scheduler.sv
// Admission controller in front of readback_engine: gates read sequences on buffer space and an
// outstanding-read limit, and orders flush / mode switch after all admitted reads have returned.
module readback_scheduler
    import readback_scheduler_pkg::*;
#(
    parameter int unsigned MAX_OUT = 1024,
    parameter int unsigned CNT_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_reads,
    output logic             req_ready,
    input  logic [CNT_W-1:0] buffer_space,
    input  logic             user_rd_done,
    input  logic             flush_req,
    input  logic             mode_req,
    output logic             read_seq_incoming,
    output logic [CNT_W-1:0] incoming_reads,
    output logic             flush,
    output logic             switch_mode,
    output logic             mode,
    output logic [CNT_W-1:0] outstanding,
    output logic             busy,
    output logic [1:0]       err
);

    localparam logic [CNT_W:0] MaxOut = (CNT_W + 1)'(MAX_OUT);

    rbs_state_e            state_q;
    rbs_pend_e             pend_q;
    logic [CoolCntW-1:0]   cool_q;
    logic                  announce_q;
    logic [CNT_W-1:0]      incoming_q;
    logic                  flush_q;
    logic                  switch_q;
    logic                  mode_q;
    logic                  oversize_err_q;

    logic [CNT_W-1:0]      out_cnt;
    logic                  underflow;
    logic [CNT_W:0]        sum_out;
    logic                  take;
    logic                  is_zero;
    logic                  is_oversize;
    logic                  fits;
    logic                  admit;
    logic [CNT_W-1:0]      admit_cnt;

    // Zero-length and oversize sequences are consumed regardless of space; only real
    // admissions need both the buffer and the outstanding limit to hold the whole sequence.
    always_comb begin
        sum_out     = {1'b0, out_cnt} + {1'b0, req_reads};
        take        = (state_q == RbsIdle) && req_valid && !flush_req && !mode_req;
        is_zero     = (req_reads == '0);
        is_oversize = ({1'b0, req_reads} > MaxOut);
        fits        = (req_reads <= buffer_space) && (sum_out <= MaxOut);
        req_ready   = take && (is_zero || is_oversize || fits);
        admit       = take && !is_zero && !is_oversize && fits;
        admit_cnt   = admit ? req_reads : '0;
    end

    rd_outstanding_ctr #(
        .CNT_W (CNT_W)
    ) u_out_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (admit_cnt),
        .dec       (user_rd_done),
        .count     (out_cnt),
        .underflow (underflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RbsIdle;
            pend_q         <= PendFlush;
            cool_q         <= '0;
            announce_q     <= 1'b0;
            incoming_q     <= '0;
            flush_q        <= 1'b0;
            switch_q       <= 1'b0;
            mode_q         <= ReadMode;
            oversize_err_q <= 1'b0;
        end else begin
            announce_q <= 1'b0;
            incoming_q <= '0;
            flush_q    <= 1'b0;
            switch_q   <= 1'b0;

            if (req_ready && is_oversize) begin
                oversize_err_q <= 1'b1;
            end

            unique case (state_q)
                RbsIdle: begin
                    if (flush_req) begin
                        pend_q  <= PendFlush;
                        state_q <= RbsDrain;
                    end else if (mode_req) begin
                        pend_q  <= PendMode;
                        state_q <= RbsDrain;
                    end else if (admit) begin
                        announce_q <= 1'b1;
                        incoming_q <= req_reads;
                        cool_q     <= CoolCntW'(RbsCoolCyc - 1);
                        state_q    <= RbsCool;
                    end
                end
                RbsCool: begin
                    if (cool_q == '0) begin
                        state_q <= RbsIdle;
                    end else begin
                        cool_q <= cool_q - 1'b1;
                    end
                end
                RbsDrain: begin
                    if (out_cnt == '0) begin
                        if (pend_q == PendFlush) begin
                            flush_q <= 1'b1;
                            state_q <= RbsFlush;
                        end else begin
                            switch_q <= 1'b1;
                            mode_q   <= ~mode_q;
                            state_q  <= RbsSwitch;
                        end
                    end
                end
                RbsFlush:  state_q <= RbsIdle;
                RbsSwitch: state_q <= RbsIdle;
                default:   state_q <= RbsIdle;
            endcase
        end
    end

    assign read_seq_incoming = announce_q;
    assign incoming_reads    = incoming_q;
    assign flush             = flush_q;
    assign switch_mode       = switch_q;
    assign mode              = mode_q;
    assign outstanding       = out_cnt;
    assign busy              = (state_q != RbsIdle) || (out_cnt != '0);
    assign err               = {oversize_err_q, underflow};

endmodule

// File: tb/tb_readback_scheduler.sv
// Directed test-plan steps followed by a randomized phase checked against an admission-rule model.
module tb_readback_scheduler;

    localparam int CW   = 12;
    localparam int MAXO = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [CW-1:0] req_reads;
    logic          req_ready;
    logic [CW-1:0] buffer_space;
    logic          user_rd_done;
    logic          flush_req;
    logic          mode_req;
    logic          read_seq_incoming;
    logic [CW-1:0] incoming_reads;
    logic          flush;
    logic          switch_mode;
    logic          mode;
    logic [CW-1:0] outstanding;
    logic          busy;
    logic [1:0]    err;

    int n_checks = 0;
    int n_fail   = 0;

    readback_scheduler #(
        .MAX_OUT (MAXO),
        .CNT_W   (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_reads         (req_reads),
        .req_ready         (req_ready),
        .buffer_space      (buffer_space),
        .user_rd_done      (user_rd_done),
        .flush_req         (flush_req),
        .mode_req          (mode_req),
        .read_seq_incoming (read_seq_incoming),
        .incoming_reads    (incoming_reads),
        .flush             (flush),
        .switch_mode       (switch_mode),
        .mode              (mode),
        .outstanding       (outstanding),
        .busy              (busy),
        .err               (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string pfx);
        chk({pfx, " req_ready"},   32'(req_ready), 0);
        chk({pfx, " announce"},    32'(read_seq_incoming), 0);
        chk({pfx, " incoming"},    32'(incoming_reads), 0);
        chk({pfx, " flush"},       32'(flush), 0);
        chk({pfx, " switch_mode"}, 32'(switch_mode), 0);
        chk({pfx, " mode"},        32'(mode), 0);
        chk({pfx, " outstanding"}, 32'(outstanding), 0);
        chk({pfx, " busy"},        32'(busy), 0);
        chk({pfx, " err"},         32'(err), 0);
    endtask

    // Drive the cycle's inputs right after the falling edge, then let comb logic settle.
    task automatic cyc_start();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int   m_out;
        int   next_ok;
        int   ann;
        int   ri;
        int   bi;
        int   tot;
        bit   vi;
        bit   di;
        bit   idle;
        bit   exp_ready;
        bit   adm;
        logic [1:0] m_err;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_reads    = '0;
        buffer_space = '0;
        user_rd_done = 1'b0;
        flush_req    = 1'b0;
        mode_req     = 1'b0;
        #1;
        chk_reset_outs("reset");
        cyc_start();
        cyc_start();
        rst_n = 1'b1;

        // Basic admit, announce timing and 3-cycle admit spacing.
        cyc_start();
        req_valid = 1'b1; req_reads = 12'd8; buffer_space = 12'd2048;
        settle();
        chk("t1 ready c0", 32'(req_ready), 1);
        cyc_start();
        req_reads = 12'd2;
        settle();
        chk("t1 announce c1", 32'(read_seq_incoming), 1);
        chk("t1 incoming c1", 32'(incoming_reads), 8);
        chk("t1 outstanding c1", 32'(outstanding), 8);
        chk("t1 busy c1", 32'(busy), 1);
        chk("t1 ready c1", 32'(req_ready), 0);
        cyc_start();
        settle();
        chk("t1 announce c2", 32'(read_seq_incoming), 0);
        chk("t1 incoming c2", 32'(incoming_reads), 0);
        chk("t1 ready c2", 32'(req_ready), 0);
        cyc_start();
        settle();
        chk("t1 ready c3", 32'(req_ready), 1);
        cyc_start();
        req_valid = 1'b0;
        settle();
        chk("t1 announce2", 32'(incoming_reads), 2);
        chk("t1 outstanding 10", 32'(outstanding), 10);
        for (int i = 0; i < 10; i++) begin
            cyc_start();
            user_rd_done = 1'b1;
        end
        cyc_start();
        user_rd_done = 1'b0;
        settle();
        chk("t1 drained", 32'(outstanding), 0);
        chk("t1 idle busy", 32'(busy), 0);

        // Buffer-space gating: 5 reads do not fit in 4, fit in 5.
        cyc_start();
        req_valid = 1'b1; req_reads = 12'd5; buffer_space = 12'd4;
        settle();
        chk("t2 no space a", 32'(req_ready), 0);
        cyc_start();
        settle();
        chk("t2 no space b", 32'(req_ready), 0);
        cyc_start();
        buffer_space = 12'd5;
        settle();
        chk("t2 space ok", 32'(req_ready), 1);

        // Flush waits for outstanding to drain, then pulses once.
        cyc_start();
        req_valid = 1'b0; user_rd_done = 1'b1; buffer_space = 12'd2048;
        settle();
        chk("t2 announce", 32'(incoming_reads), 5);
        chk("t2 outstanding", 32'(outstanding), 5);
        cyc_start();
        settle();
        chk("t3 out 4", 32'(outstanding), 4);
        cyc_start();
        user_rd_done = 1'b0; flush_req = 1'b1;
        settle();
        chk("t3 out 3", 32'(outstanding), 3);
        cyc_start();
        req_valid = 1'b1; req_reads = 12'd1;
        settle();
        chk("t3 no ready in drain", 32'(req_ready), 0);
        chk("t3 flush early", 32'(flush), 0);
        chk("t3 busy drain", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            cyc_start();
            req_valid = 1'b0; user_rd_done = 1'b1;
            settle();
            chk("t3 flush while draining", 32'(flush), 0);
        end
        cyc_start();
        user_rd_done = 1'b0;
        settle();
        chk("t3 out zero", 32'(outstanding), 0);
        chk("t3 flush not yet", 32'(flush), 0);
        cyc_start();
        settle();
        chk("t3 flush pulse", 32'(flush), 1);
        flush_req = 1'b0;
        cyc_start();
        settle();
        chk("t3 flush single", 32'(flush), 0);
        chk("t3 idle", 32'(busy), 0);

        // Mode request beats a pending read request, which is admitted afterwards.
        cyc_start();
        mode_req = 1'b1; req_valid = 1'b1; req_reads = 12'd4;
        settle();
        chk("t4 ready blocked", 32'(req_ready), 0);
        cyc_start();
        settle();
        chk("t4 drain ready", 32'(req_ready), 0);
        chk("t4 switch early", 32'(switch_mode), 0);
        cyc_start();
        settle();
        chk("t4 switch pulse", 32'(switch_mode), 1);
        chk("t4 mode diff", 32'(mode), 1);
        chk("t4 ready in switch", 32'(req_ready), 0);
        mode_req = 1'b0;
        cyc_start();
        settle();
        chk("t4 switch single", 32'(switch_mode), 0);
        chk("t4 ready after", 32'(req_ready), 1);
        cyc_start();
        req_valid = 1'b0;
        settle();
        chk("t4 announce", 32'(incoming_reads), 4);
        chk("t4 mode held", 32'(mode), 1);
        for (int i = 0; i < 4; i++) begin
            cyc_start();
            user_rd_done = 1'b1;
        end
        cyc_start();
        user_rd_done = 1'b0;
        settle();
        chk("t4 drained", 32'(outstanding), 0);

        // Underflow and oversize errors.
        cyc_start();
        user_rd_done = 1'b1;
        cyc_start();
        user_rd_done = 1'b0;
        req_valid = 1'b1; req_reads = 12'd1025;
        settle();
        chk("t5 out sat", 32'(outstanding), 0);
        chk("t5 err uf", 32'(err), 2'b01);
        chk("t5 oversize ready", 32'(req_ready), 1);
        cyc_start();
        req_valid = 1'b0;
        settle();
        chk("t5 err both", 32'(err), 2'b11);
        chk("t5 no announce", 32'(read_seq_incoming), 0);
        chk("t5 out still 0", 32'(outstanding), 0);

        // Asynchronous reset during COOL.
        cyc_start();
        req_valid = 1'b1; req_reads = 12'd10;
        settle();
        chk("t6 ready", 32'(req_ready), 1);
        cyc_start();
        req_valid = 1'b0;
        settle();
        chk("t6 out 10", 32'(outstanding), 10);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("t6 async");
        cyc_start();
        rst_n = 1'b1;
        settle();
        chk("t6 no announce", 32'(read_seq_incoming), 0);
        chk("t6 out after", 32'(outstanding), 0);

        // Randomized phase: outputs follow the admission rules and COOL spacing.
        m_out   = 0;
        next_ok = 0;
        ann     = 0;
        m_err   = 2'b00;
        for (int c = 0; c < 600; c++) begin
            cyc_start();
            vi = ($urandom % 2) == 0;
            case ($urandom % 10)
                0:       ri = 0;
                1:       ri = 1025 + int'($urandom % 100);
                2:       ri = int'($urandom_range(300, 700));
                default: ri = 1 + int'($urandom % 40);
            endcase
            bi = (($urandom % 2) == 0) ? 2048 : int'($urandom % 64);
            if (m_out > 0) di = ($urandom % 3) != 0;
            else           di = ($urandom % 40) == 0;
            req_valid    = vi;
            req_reads    = CW'(ri);
            buffer_space = CW'(bi);
            user_rd_done = di;
            settle();

            idle      = c >= next_ok;
            exp_ready = idle && vi && (ri == 0 || ri > MAXO || (ri <= bi && m_out + ri <= MAXO));
            chk("rnd ready", 32'(req_ready), 32'(exp_ready));
            chk("rnd outstanding", 32'(outstanding), 32'(m_out));
            chk("rnd announce", 32'(read_seq_incoming), 32'(ann != 0));
            chk("rnd incoming", 32'(incoming_reads), 32'(ann));
            chk("rnd busy", 32'(busy), 32'(!idle || m_out != 0));
            chk("rnd err", 32'(err), 32'(m_err));

            ann = 0;
            adm = exp_ready && ri != 0 && ri <= MAXO;
            if (exp_ready && ri > MAXO) m_err[1] = 1'b1;
            tot = m_out + (adm ? ri : 0);
            if (di) begin
                if (tot == 0) m_err[0] = 1'b1;
                else          tot--;
            end
            m_out = tot;
            if (adm) begin
                next_ok = c + 3;
                ann     = ri;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
